// File: rtl/usequencer_cstore_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : usequencer_cstore_ctrl_if
//  Description : Bundle of the sequencer's status, control-store and
//                datapath-control signals.
//                master : the sequencer (drives CS address and MIR fields)
//                slave  : the environment (flags, IR fields, memory ready,
//                         control-store data)
//  Ports       : none (signal bundle only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface usequencer_cstore_ctrl_if #(
    parameter int DATAWIDTH_UADDR = 11,
    parameter int DATAWIDTH_MIR   = 41
);
    // Inputs to the sequencer
    logic [3:0]                 uSequencer_FLAGs_In;        // PSR {n,z,v,c}
    logic                       uSequencer_IR13_In;
    logic [1:0]                 uSequencer_RegIR_OP_In;
    logic [2:0]                 uSequencer_RegIR_OP2_In;
    logic [5:0]                 uSequencer_RegIR_OP3_In;
    logic                       uSequencer_MemReady_InHigh;
    logic [DATAWIDTH_MIR-1:0]   uSequencer_CSData_In;
    // Outputs from the sequencer
    logic [DATAWIDTH_UADDR-1:0] uSequencer_CSAddress_Out;
    logic [5:0]                 uSequencer_A_Out;
    logic                       uSequencer_AMUX_Out;
    logic [5:0]                 uSequencer_B_Out;
    logic                       uSequencer_BMUX_Out;
    logic [5:0]                 uSequencer_C_Out;
    logic                       uSequencer_CMUX_Out;
    logic                       uSequencer_RD_Out;
    logic                       uSequencer_WR_Out;
    logic [3:0]                 uSequencer_ALU_Out;
    logic                       uSequencer_CWrite_OutHigh;
    logic                       uSequencer_Stall_OutHigh;
    logic [DATAWIDTH_UADDR-1:0] uSequencer_uPC_Out;

    modport master (
        input  uSequencer_FLAGs_In, uSequencer_IR13_In, uSequencer_RegIR_OP_In,
               uSequencer_RegIR_OP2_In, uSequencer_RegIR_OP3_In,
               uSequencer_MemReady_InHigh, uSequencer_CSData_In,
        output uSequencer_CSAddress_Out, uSequencer_A_Out, uSequencer_AMUX_Out,
               uSequencer_B_Out, uSequencer_BMUX_Out, uSequencer_C_Out,
               uSequencer_CMUX_Out, uSequencer_RD_Out, uSequencer_WR_Out,
               uSequencer_ALU_Out, uSequencer_CWrite_OutHigh,
               uSequencer_Stall_OutHigh, uSequencer_uPC_Out
    );

    modport slave (
        output uSequencer_FLAGs_In, uSequencer_IR13_In, uSequencer_RegIR_OP_In,
               uSequencer_RegIR_OP2_In, uSequencer_RegIR_OP3_In,
               uSequencer_MemReady_InHigh, uSequencer_CSData_In,
        input  uSequencer_CSAddress_Out, uSequencer_A_Out, uSequencer_AMUX_Out,
               uSequencer_B_Out, uSequencer_BMUX_Out, uSequencer_C_Out,
               uSequencer_CMUX_Out, uSequencer_RD_Out, uSequencer_WR_Out,
               uSequencer_ALU_Out, uSequencer_CWrite_OutHigh,
               uSequencer_Stall_OutHigh, uSequencer_uPC_Out
    );
endinterface
`default_nettype wire

// File: rtl/usequencer_cstore_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usequencer_cstore_ctrl
//  Description : Microprogram sequencer. Holds uPC and MIR, addresses the
//                asynchronous control-store ROM, selects the next
//                micro-address from the MIR COND field and stalls on
//                memory RD/WR until memory acknowledges.
//  Ports       : uSequencer_CLOCK_50     - clock, rising edge
//                uSequencer_Reset_InLow  - asynchronous reset, active low
//                bus (master)            - flags/IR/memory-ready/CS data in;
//                                          CS address, MIR fields, CWrite,
//                                          Stall and uPC out
//  Revision    : 1.0 - initial release
// ============================================================================
module usequencer_cstore_ctrl #(
    parameter int                         DATAWIDTH_UADDR = 11,
    parameter int                         DATAWIDTH_MIR   = 41,
    parameter logic [DATAWIDTH_UADDR-1:0] DATA_UPC_INIT   = '0
) (
    input  wire logic                  uSequencer_CLOCK_50,
    input  wire logic                  uSequencer_Reset_InLow,
    usequencer_cstore_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [DATAWIDTH_UADDR-1:0] C_UPC_ONE = {{(DATAWIDTH_UADDR-1){1'b0}}, 1'b1};

    state_t                     state_q, state_d;
    logic [DATAWIDTH_UADDR-1:0] upc_q,   upc_d;
    logic [DATAWIDTH_MIR-1:0]   mir_q,   mir_d;

    logic [DATAWIDTH_UADDR-1:0] w_cs_addr;
    logic [DATAWIDTH_UADDR-1:0] w_next_addr;
    logic [DATAWIDTH_UADDR-1:0] w_seq_addr;
    logic [DATAWIDTH_UADDR-1:0] w_jump_addr;
    logic [DATAWIDTH_UADDR-1:0] w_decode_addr;
    logic [5:0]                 w_decode_f;
    logic [2:0]                 w_cond;
    logic                       w_take_jump;
    logic                       w_mem_req;
    logic                       w_stall;
    logic                       w_cwrite;

    assign w_cond      = mir_q[13:11];
    assign w_jump_addr = mir_q[10:0];
    assign w_seq_addr  = upc_q + C_UPC_ONE;           // wraps naturally at 2^width
    assign w_mem_req   = mir_q[19] | mir_q[18];       // RD and WR share one handshake

    // Format-3 instructions (OP!=0) dispatch on OP3; format-2 (OP==0) on OP2.
    assign w_decode_f    = (bus.uSequencer_RegIR_OP_In != 2'b00) ? bus.uSequencer_RegIR_OP3_In
                                                                 : {bus.uSequencer_RegIR_OP2_In, 3'b000};
    assign w_decode_addr = {1'b1, bus.uSequencer_RegIR_OP_In, w_decode_f, 2'b00};

    // Branch condition is evaluated from the live inputs, so a release out of
    // WAIT uses whatever flags are present on that cycle.
    always_comb begin
        w_take_jump = 1'b0;
        case (w_cond)
            3'd1:    w_take_jump = bus.uSequencer_FLAGs_In[3];
            3'd2:    w_take_jump = bus.uSequencer_FLAGs_In[2];
            3'd3:    w_take_jump = bus.uSequencer_FLAGs_In[1];
            3'd4:    w_take_jump = bus.uSequencer_FLAGs_In[0];
            3'd5:    w_take_jump = bus.uSequencer_IR13_In;
            3'd6:    w_take_jump = 1'b1;
            default: w_take_jump = 1'b0;
        endcase
    end

    always_comb begin
        w_next_addr = w_seq_addr;
        if (w_cond == 3'd7) begin
            w_next_addr = w_decode_addr;
        end else if (w_take_jump) begin
            w_next_addr = w_jump_addr;
        end
    end

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        mir_d     = mir_q;
        w_cs_addr = upc_q;
        w_stall   = 1'b0;
        w_cwrite  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                w_cs_addr = DATA_UPC_INIT;
                mir_d     = bus.uSequencer_CSData_In;
                upc_d     = DATA_UPC_INIT;
                state_d   = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                if (w_mem_req && !bus.uSequencer_MemReady_InHigh) begin
                    // Hold the current microword; keep the ROM pointed at it.
                    w_stall = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    w_cs_addr = w_next_addr;
                    mir_d     = bus.uSequencer_CSData_In;
                    upc_d     = w_next_addr;
                    w_cwrite  = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge uSequencer_CLOCK_50 or negedge uSequencer_Reset_InLow) begin
        if (!uSequencer_Reset_InLow) begin
            state_q <= ST_BOOT;
            upc_q   <= DATA_UPC_INIT;
            mir_q   <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            mir_q   <= mir_d;
        end
    end

    assign bus.uSequencer_CSAddress_Out  = w_cs_addr;
    assign bus.uSequencer_A_Out          = mir_q[40:35];
    assign bus.uSequencer_AMUX_Out       = mir_q[34];
    assign bus.uSequencer_B_Out          = mir_q[33:28];
    assign bus.uSequencer_BMUX_Out       = mir_q[27];
    assign bus.uSequencer_C_Out          = mir_q[26:21];
    assign bus.uSequencer_CMUX_Out       = mir_q[20];
    assign bus.uSequencer_RD_Out         = mir_q[19];
    assign bus.uSequencer_WR_Out         = mir_q[18];
    assign bus.uSequencer_ALU_Out        = mir_q[17:14];
    assign bus.uSequencer_CWrite_OutHigh = w_cwrite;
    assign bus.uSequencer_Stall_OutHigh  = w_stall;
    assign bus.uSequencer_uPC_Out        = upc_q;

endmodule
`default_nettype wire

// File: tb/tb_usequencer_cstore_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usequencer_cstore_ctrl
//  Description : Self-checking bench for usequencer_cstore_ctrl. An array
//                stands in for the asynchronous control-store ROM; a
//                behavioural model tracks uPC/MIR and predicts outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usequencer_cstore_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [40:0] rom [2048];

    // Model state: "booting" means the next edge loads the init microword.
    bit          m_boot;
    int          m_upc;
    logic [40:0] m_mir;

    usequencer_cstore_ctrl_if bus ();

    usequencer_cstore_ctrl dut (
        .uSequencer_CLOCK_50    (clk),
        .uSequencer_Reset_InLow (rst_n),
        .bus                    (bus.master)
    );

    assign bus.uSequencer_CSData_In = rom[bus.uSequencer_CSAddress_Out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] mk(input int cond, input int jaddr, input logic [1:0] mem);
        logic [40:0] w;
        w        = 41'({$urandom(), $urandom()});
        w[19:18] = mem;
        w[13:11] = 3'(cond);
        w[10:0]  = 11'(jaddr);
        return w;
    endfunction

    // Next micro-address from the sequencing rules, in plain arithmetic.
    function automatic int model_na(input logic [40:0] w, input int upc);
        int  cond;
        int  f;
        int  op;
        bit  take;
        cond = int'(w[13:11]);
        op   = int'(bus.uSequencer_RegIR_OP_In);
        if (cond == 7) begin
            f = (op != 0) ? int'(bus.uSequencer_RegIR_OP3_In) : int'(bus.uSequencer_RegIR_OP2_In) * 8;
            return 1024 + op * 256 + f * 4;
        end
        case (cond)
            1:       take = bus.uSequencer_FLAGs_In[3];
            2:       take = bus.uSequencer_FLAGs_In[2];
            3:       take = bus.uSequencer_FLAGs_In[1];
            4:       take = bus.uSequencer_FLAGs_In[0];
            5:       take = bus.uSequencer_IR13_In;
            6:       take = 1'b1;
            default: take = 1'b0;
        endcase
        return take ? int'(w[10:0]) : (upc + 1) % 2048;
    endfunction

    function automatic logic [26:0] dut_fields();
        return {bus.uSequencer_A_Out, bus.uSequencer_AMUX_Out, bus.uSequencer_B_Out,
                bus.uSequencer_BMUX_Out, bus.uSequencer_C_Out, bus.uSequencer_CMUX_Out,
                bus.uSequencer_RD_Out, bus.uSequencer_WR_Out, bus.uSequencer_ALU_Out};
    endfunction

    task automatic rand_inputs();
        bus.uSequencer_FLAGs_In        = 4'($urandom());
        bus.uSequencer_IR13_In         = 1'($urandom());
        bus.uSequencer_RegIR_OP_In     = 2'($urandom());
        bus.uSequencer_RegIR_OP2_In    = 3'($urandom());
        bus.uSequencer_RegIR_OP3_In    = 6'($urandom());
        bus.uSequencer_MemReady_InHigh = 1'($urandom());
    endtask

    // Called just after a falling edge with inputs already applied. Checks
    // outputs against the model (and against want_cs when >= 0), then
    // advances the model across the rising edge.
    task automatic step(input int want_cs);
        bit st;
        int exp_cs;
        #1;
        st     = !m_boot && (m_mir[19] || m_mir[18]) && !bus.uSequencer_MemReady_InHigh;
        exp_cs = m_boot ? 0 : (st ? m_upc : model_na(m_mir, m_upc));
        check_val("cs_addr", 64'(bus.uSequencer_CSAddress_Out), 64'(exp_cs));
        if (want_cs >= 0) check_val("cs_addr_directed", 64'(bus.uSequencer_CSAddress_Out), 64'(want_cs));
        check_val("stall",  64'(bus.uSequencer_Stall_OutHigh), 64'(st));
        check_val("cwrite", 64'(bus.uSequencer_CWrite_OutHigh), 64'(!m_boot && !st));
        check_val("upc",    64'(bus.uSequencer_uPC_Out), 64'(m_upc));
        check_val("fields", 64'(dut_fields()), 64'(m_mir[40:14]));
        @(posedge clk);
        if (m_boot) begin
            m_mir  = rom[0];
            m_upc  = 0;
            m_boot = 1'b0;
        end else if (!st) begin
            m_mir = rom[exp_cs];
            m_upc = exp_cs;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        check_val("rst_cs",     64'(bus.uSequencer_CSAddress_Out), 64'd0);
        check_val("rst_fields", 64'(dut_fields()), 64'd0);
        check_val("rst_cwrite", 64'(bus.uSequencer_CWrite_OutHigh), 64'd0);
        check_val("rst_stall",  64'(bus.uSequencer_Stall_OutHigh), 64'd0);
        check_val("rst_upc",    64'(bus.uSequencer_uPC_Out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_boot = 1'b1;
        m_upc  = 0;
        m_mir  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        m_boot   = 1'b1;
        m_upc    = 0;
        m_mir    = '0;
        for (int i = 0; i < 2048; i++) rom[i] = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)), 2'b00);
        rom[0]     = mk(0, 0, 2'b00);
        rom[1]     = mk(1, 5, 2'b00);
        rom[5]     = mk(0, 0, 2'b00);
        rom[6]     = mk(6, 2047, 2'b00);
        rom[2047]  = mk(0, 0, 2'b00);
        rom[2]     = mk(6, 11'h020, 2'b00);
        rom[11'h020] = mk(2, 11'h100, 2'b00);
        rom[11'h021] = mk(2, 11'h100, 2'b00);
        rom[11'h100] = mk(7, 0, 2'b00);
        rom[11'h640] = mk(7, 0, 2'b00);
        rom[11'h440] = mk(0, 0, 2'b10);
        rom[11'h441] = mk(5, 11'h300, 2'b11);
        rand_inputs();
        bus.uSequencer_MemReady_InHigh = 1'b1;
        #2;
        @(negedge clk);
        reset_now();

        // Directed walk: boot, sequential, wrap, conditional, decode, stall.
        rand_inputs(); bus.uSequencer_MemReady_InHigh = 1'b1;
        step(0);                                             // BOOT
        check_val("upc_after_boot", 64'(bus.uSequencer_uPC_Out), 64'd0);
        rand_inputs(); bus.uSequencer_MemReady_InHigh = 1'b1;
        step(1);                                             // uPC 0, COND 0
        rand_inputs(); bus.uSequencer_FLAGs_In[3] = 1'b1;
        step(5);                                             // n taken
        rand_inputs();
        step(6);                                             // uPC 5 -> 6
        rand_inputs();
        step(2047);
        rand_inputs();
        step(0);                                             // wrap
        rand_inputs();
        step(1);
        rand_inputs(); bus.uSequencer_FLAGs_In[3] = 1'b0;
        step(2);                                             // n not taken
        rand_inputs();
        step(11'h020);
        rand_inputs(); bus.uSequencer_FLAGs_In[2] = 1'b0;
        step(11'h021);                                       // z=0 at 0x20
        rand_inputs(); bus.uSequencer_FLAGs_In[2] = 1'b1;
        step(11'h100);                                       // z=1
        rand_inputs(); bus.uSequencer_RegIR_OP_In = 2'b10; bus.uSequencer_RegIR_OP3_In = 6'h10;
        step(11'h640);                                       // format-3 decode
        rand_inputs(); bus.uSequencer_RegIR_OP_In = 2'b00; bus.uSequencer_RegIR_OP2_In = 3'b010;
        step(-1);                                            // format-2 decode (model)
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); bus.uSequencer_MemReady_InHigh = 1'b0;
            step(11'h440);                                   // RD stalled
        end
        rand_inputs(); bus.uSequencer_MemReady_InHigh = 1'b1;
        step(11'h441);                                       // released
        rand_inputs(); bus.uSequencer_MemReady_InHigh = 1'b0;
        step(11'h441);                                       // RD+WR stalled
        reset_now();                                         // reset during WAIT

        // Randomized run over a fully random control store.
        for (int i = 0; i < 2048; i++)
            rom[i] = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)), 2'($urandom()));
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 249) == 0) reset_now();
            else step(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
